reg_write_buffer: RTL

Write-back buffer sitting directly upstream of the 32x32 register file. Accepts register writes from the execute/memory stages into a small FIFO, drains them one per cycle into the register file's write port, and arbitrates the register file's mutually exclusive READ/WRITE controls against operand-read requests. Pending writes are forwarded to read requests so the decode stage always sees the newest value.

---
 rtl/reg_write_buffer.sv | 100 ++++++++++
 1 files changed

// File: rtl/reg_write_buffer.sv
// Write-back FIFO in front of the 32x32 register file: queues writes, drains one per cycle, forwards pending data to operand reads.
// Latency: push-to-rf_write >= 1 cycle, reads are combinational (0 cycles). Backpressure: push_ready low when full; a read stalls while full.
// Reads win the register-file port over drains, except when full, where a drain is forced so the buffer cannot deadlock.
module reg_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        push_valid,
    input  logic [4:0]  push_addr,
    input  logic [31:0] push_data,
    output logic        push_ready,
    input  logic        rd_req,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic        rd_ack,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic        empty,
    output logic [4:0]  rf_addr_w,
    output logic [31:0] rf_data_w,
    output logic [4:0]  rf_addr_r1,
    output logic [4:0]  rf_addr_r2,
    output logic        rf_read,
    output logic        rf_write,
    input  logic [31:0] rf_data_r1,
    input  logic [31:0] rf_data_r2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            not_full;
    logic            push_keep;
    logic [31:0]     fwd1;
    logic [31:0]     fwd2;
    logic [PW-1:0]   idx;

    assign not_full   = count < CW'(DEPTH);
    assign push_ready = !RST && not_full;
    // Register 0 writes complete the handshake but never occupy an entry.
    assign push_keep  = push_valid && push_ready && (push_addr != 5'd0);

    assign rd_ack     = !RST && rd_req && not_full;
    assign rf_read    = rd_ack;
    assign rf_write   = !RST && !rd_ack && (count != '0);
    assign rf_addr_w  = mem[head].addr;
    assign rf_data_w  = mem[head].data;
    assign rf_addr_r1 = rd_addr1;
    assign rf_addr_r2 = rd_addr2;
    assign empty      = (count == '0);

    // Walk oldest to newest so the newest matching entry overrides earlier ones.
    always_comb begin
        fwd1 = rf_data_r1;
        fwd2 = rf_data_r2;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if (mem[idx].addr == rd_addr1) fwd1 = mem[idx].data;
                if (mem[idx].addr == rd_addr2) fwd2 = mem[idx].data;
            end
        end
        if (rd_addr1 == 5'd0) fwd1 = '0;
        if (rd_addr2 == 5'd0) fwd2 = '0;
    end

    assign rd_data1 = rd_ack ? fwd1 : '0;
    assign rd_data2 = rd_ack ? fwd2 : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_keep) tail <= tail + 1'b1;
            if (rf_write)  head <= head + 1'b1;
            case ({push_keep, rf_write})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_keep) mem[tail] <= '{addr: push_addr, data: push_data};
    end

endmodule
